sync_fifo_ctrl: RTL and testbench
=================================

Name: sync_fifo_ctrl

Overview:
Single-clock FIFO controller that sequences a dual-port RAM instance (write port and read port both clocked by clk) as a circular buffer.
- Owns the write and read pointers, full/empty/almost flags and occupancy count.
- Gates RAM w_en/r_en so the RAM is never overwritten or over-read.
- Sits between a producer/consumer pair and the RAM; the RAM's data_out register supplies rd_data with 1-cycle latency.

Parameters:
ADDR_WIDTH, 10, RAM address width; FIFO depth DEPTH = 2**ADDR_WIDTH
DATA_WIDTH, 32, data width passed through to/from RAM
AFULL_THRESH, DEPTH-4, almost_full asserted when count >= AFULL_THRESH
AEMPTY_THRESH, 4, almost_empty asserted when count <= AEMPTY_THRESH

Ports:
clk  input  1  single clock; also drives RAM w_clk and r_clk
rst_n  input  1  asynchronous active-low reset; also routed to RAM rst_n
wr_en  input  1  producer write request
wr_data  input  DATA_WIDTH  producer write data
rd_en  input  1  consumer read request
rd_data  output  DATA_WIDTH  read data (wired from RAM data_out)
rd_valid  output  1  rd_data valid, 1 cycle after accepted read
flush  input  1  synchronous clear of FIFO state
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AFULL_THRESH
almost_empty  output  1  count <= AEMPTY_THRESH
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
ram_w_addr  output  ADDR_WIDTH  to RAM w_addr
ram_w_en  output  1  to RAM w_en
ram_w_data  output  DATA_WIDTH  to RAM data_in
ram_r_addr  output  ADDR_WIDTH  to RAM r_addr
ram_r_en  output  1  to RAM r_en
ram_r_data  input  DATA_WIDTH  from RAM data_out

Behaviour:
- Pointers wptr/rptr are ADDR_WIDTH+1 bits. The MSB is the wrap bit. RAM addresses are the low ADDR_WIDTH bits.
- Reset values: wptr=0, rptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0 (AFULL_THRESH>0), rd_valid=0.
- Write accept: wr_acc = wr_en & ~full & ~flush. Read accept: rd_acc = rd_en & ~empty & ~flush.
- Both use the registered flags of the current cycle. A write while full is rejected even if a read is accepted in the same cycle. A read while empty is rejected even if a write is accepted in the same cycle.
- ram_w_en = wr_acc, ram_w_addr = wptr[ADDR_WIDTH-1:0], ram_w_data = wr_data. All are combinational, so the RAM captures data on the same edge.
- ram_r_en = rd_acc, ram_r_addr = rptr[ADDR_WIDTH-1:0]. The RAM registers data, so rd_data is valid on the cycle after acceptance. rd_valid is a register of rd_acc.
- On each edge: wptr += wr_acc, rptr += rd_acc (mod 2**(ADDR_WIDTH+1)). count goes +1 on write only, -1 on read only, and is unchanged on both or neither.
- full, empty, almost_* and count are registered from next-state values, so they are exact on the cycle after the edge. No combinational path exists from wr_en/rd_en to the flags.
- Wrap-around: after 2**ADDR_WIDTH accepted writes, ram_w_addr returns to 0 and the wptr MSB toggles. Flags remain correct across any number of wraps.
- flush=1: next edge sets wptr=rptr=0, count=0, empty=1, rd_valid=0. Simultaneous wr_en/rd_en are ignored. RAM contents are not cleared.
- rst_n low mid-operation: all registers clear asynchronously and an in-flight rd_valid is dropped. The RAM also clears via the shared rst_n.

Optional Feature:
Macro SYNC_FIFO_ERR_FLAG_EN.
- Defined: adds outputs overflow and underflow (1 bit each, reset 0).
  - overflow sets sticky on wr_en & full; underflow sets sticky on rd_en & empty.
  - Both clear only on flush or reset.
- Undefined: the ports and their logic are absent; rejected requests are silently dropped.

Test Plan:
(ADDR_WIDTH=4, DEPTH=16, AFULL_THRESH=12, AEMPTY_THRESH=4)
- Reset, then idle → empty=1, full=0, count=0, almost_empty=1, rd_valid=0, ram_w_en=ram_r_en=0.
- Write 0x00..0x0F on 16 consecutive cycles, then read 16 → full=1 and count=16 after the 16th write. almost_full rises when count reaches 12. rd_data = 0x00..0x0F in order, each 1 cycle after rd_en. Ends with empty=1.
- Full FIFO, wr_en=1 with data 0xDEAD → ram_w_en=0, count stays 16, the 0xDEAD word is never read back. With SYNC_FIFO_ERR_FLAG_EN defined, overflow=1.
- Count=5, wr_en=rd_en=1 for 40 cycles with incrementing data → count stays 5, pointers wrap at least twice, data order preserved. Empty FIFO with wr_en=rd_en=1 → write accepted, read rejected, count=1.
- Count=9, flush=1 with wr_en=rd_en=1 → next cycle count=0, empty=1, ram_w_addr=0, no RAM write. A subsequent write/read returns the new data.
- Count=7 with a read accepted, rst_n pulsed low for half a cycle → rd_valid=0 and count=0 immediately. After release, the first write goes to ram_w_addr=0.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller driving an external dual-port RAM as a circular buffer.
// Define SYNC_FIFO_ERR_FLAG_EN to add sticky overflow/underflow outputs.
module sync_fifo_ctrl #(
    parameter int ADDR_WIDTH    = 10,
    parameter int DATA_WIDTH    = 32,
    parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  flush,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
`ifdef SYNC_FIFO_ERR_FLAG_EN
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic [ADDR_WIDTH-1:0] ram_w_addr,
    output logic                  ram_w_en,
    output logic [DATA_WIDTH-1:0] ram_w_data,
    output logic [ADDR_WIDTH-1:0] ram_r_addr,
    output logic                  ram_r_en,
    input  logic [DATA_WIDTH-1:0] ram_r_data
);

    localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0] wptr, rptr;
    logic [ADDR_WIDTH:0] wptr_nxt, rptr_nxt, count_nxt;
    logic                wr_acc, rd_acc;

    // Acceptance uses only registered flags, so no request-to-flag combinational path exists.
    assign wr_acc = wr_en & ~full & ~flush;
    assign rd_acc = rd_en & ~empty & ~flush;

    assign ram_w_en   = wr_acc;
    assign ram_w_addr = wptr[ADDR_WIDTH-1:0];
    assign ram_w_data = wr_data;
    assign ram_r_en   = rd_acc;
    assign ram_r_addr = rptr[ADDR_WIDTH-1:0];
    assign rd_data    = ram_r_data;

    always_comb begin
        wptr_nxt  = wptr;
        rptr_nxt  = rptr;
        count_nxt = count;
        if (flush) begin
            wptr_nxt  = '0;
            rptr_nxt  = '0;
            count_nxt = '0;
        end else begin
            if (wr_acc) wptr_nxt = wptr + ONE;
            if (rd_acc) rptr_nxt = rptr + ONE;
            if (wr_acc && !rd_acc)      count_nxt = count + ONE;
            else if (rd_acc && !wr_acc) count_nxt = count - ONE;
        end
    end

    // Stage p0 -> p1: pointers, occupancy and flags all registered from next-state values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            rd_valid     <= 1'b0;
        end else begin
            wptr         <= wptr_nxt;
            rptr         <= rptr_nxt;
            count        <= count_nxt;
            // Same low address with differing wrap bits means the writer is a whole lap ahead.
            full         <= (wptr_nxt[ADDR_WIDTH] != rptr_nxt[ADDR_WIDTH]) &&
                            (wptr_nxt[ADDR_WIDTH-1:0] == rptr_nxt[ADDR_WIDTH-1:0]);
            empty        <= (wptr_nxt == rptr_nxt);
            almost_full  <= int'(count_nxt) >= AFULL_THRESH;
            almost_empty <= int'(count_nxt) <= AEMPTY_THRESH;
            rd_valid     <= rd_acc;
        end
    end

`ifdef SYNC_FIFO_ERR_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full)  overflow  <= 1'b1;
            if (rd_en && empty) underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Randomised and directed bench for sync_fifo_ctrl against a queue-based FIFO model.
module tb_sync_fifo_ctrl;
    localparam int AW = 4, DW = 32, DEPTH = 16, AF = 12, AE = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          wr_en = 1'b0, rd_en = 1'b0, flush = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] rd_data, ram_w_data, ram_r_data;
    logic          rd_valid, full, empty, almost_full, almost_empty;
    logic [AW:0]   count;
    logic [AW-1:0] ram_w_addr, ram_r_addr;
    logic          ram_w_en, ram_r_en;
`ifdef SYNC_FIFO_ERR_FLAG_EN
    logic          overflow, underflow;
`endif

    always #5 clk = ~clk;

    sync_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .flush(flush), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
`ifdef SYNC_FIFO_ERR_FLAG_EN
        .overflow(overflow), .underflow(underflow),
`endif
        .ram_w_addr(ram_w_addr), .ram_w_en(ram_w_en), .ram_w_data(ram_w_data),
        .ram_r_addr(ram_r_addr), .ram_r_en(ram_r_en), .ram_r_data(ram_r_data)
    );

    // Dual-port RAM with registered read port, cleared output on reset
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) if (ram_w_en) mem[ram_w_addr] <= ram_w_data;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) ram_r_data <= '0;
        else if (ram_r_en) ram_r_data <= mem[ram_r_addr];

    int vectors = 0, miscompares = 0;
    logic [DW-1:0] q[$];
    int  wcnt, rcnt;
    bit  exp_rv, ovf, udf;
    logic [DW-1:0] exp_rd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        wcnt = 0; rcnt = 0; exp_rv = 0; ovf = 0; udf = 0; exp_rd = '0;
    endtask

    task automatic chk_state();
        chk("count", count, q.size());
        chk("empty", empty, q.size() == 0);
        chk("full", full, q.size() == DEPTH);
        chk("almost_full", almost_full, q.size() >= AF);
        chk("almost_empty", almost_empty, q.size() <= AE);
        chk("rd_valid", rd_valid, exp_rv);
        if (exp_rv) chk("rd_data", rd_data, exp_rd);
`ifdef SYNC_FIFO_ERR_FLAG_EN
        chk("overflow", overflow, ovf);
        chk("underflow", underflow, udf);
`endif
    endtask

    // One clock: drive inputs, check RAM strobes, advance model, check registered state
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
        bit wacc, racc;
        wr_en = w; wr_data = d; rd_en = r; flush = f;
        #1;
        wacc = w && (q.size() < DEPTH) && !f;
        racc = r && (q.size() > 0) && !f;
        chk("ram_w_en", ram_w_en, wacc);
        chk("ram_r_en", ram_r_en, racc);
        if (wacc) begin
            chk("ram_w_addr", ram_w_addr, wcnt % DEPTH);
            chk("ram_w_data", ram_w_data, d);
        end
        if (racc) chk("ram_r_addr", ram_r_addr, rcnt % DEPTH);
        @(posedge clk);
        #1;
        if (f) begin
            model_reset();
        end else begin
            if (w && q.size() == DEPTH) ovf = 1;
            if (r && q.size() == 0) udf = 1;
            if (racc) exp_rd = q.pop_front();
            if (wacc) q.push_back(d);
            wcnt += int'(wacc);
            rcnt += int'(racc);
            exp_rv = racc;
        end
        chk_state();
    endtask

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        chk_state();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        step(0, '0, 0, 0);

        // Fill to full, attempt overflow, drain in order, attempt underflow
        for (int i = 0; i < 16; i++) step(1, DW'(i), 0, 0);
        step(1, 32'hDEAD, 0, 0);
        for (int i = 0; i < 16; i++) step(0, '0, 1, 0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(0, '0, 0, 1);

        // Steady occupancy of 5 through multiple pointer wraps
        for (int i = 0; i < 5; i++) step(1, 32'h100 + DW'(i), 0, 0);
        for (int i = 0; i < 40; i++) step(1, 32'h200 + DW'(i), 1, 0);
        step(0, '0, 0, 1);
        step(1, 32'hA5A5, 1, 0);
        step(0, '0, 1, 0);

        // Flush at count 9 with simultaneous requests, then reuse
        for (int i = 0; i < 9; i++) step(1, 32'h300 + DW'(i), 0, 0);
        step(1, 32'hBAD0, 1, 1);
        step(1, 32'hC0DE, 0, 0);
        step(0, '0, 1, 0);
        step(0, '0, 0, 0);

        // Random traffic with occasional flushes
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 39) == 0));

        // Asynchronous reset with a read in flight at count 7
        step(0, '0, 0, 1);
        for (int i = 0; i < 8; i++) step(1, 32'h400 + DW'(i), 0, 0);
        step(0, '0, 1, 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst rd_valid", rd_valid, 1'b0);
        chk("rst count", count, 0);
        chk_state();
        @(negedge clk) rst_n = 1'b1;
        #1;
        step(1, 32'hF00D, 0, 0);
        step(0, '0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
